// File: rtl/sign_extend_unpacker.sv
// Unpacks a word of p_LANES signed samples and emits them one per handshake, sign-extended.
// Optional one-word prefetch slot: define SIGN_EXTEND_UNPACKER_PREFETCH_EN.
module sign_extend_unpacker #(
  parameter int p_INPUT_WIDTH  = 4,
  parameter int p_OUTPUT_WIDTH = 8,
  parameter int p_LANES        = 4,
  localparam int LW = (p_LANES > 1) ? $clog2(p_LANES) : 1
) (
  input  logic                              i_CLK,
  input  logic                              i_RST,
  input  logic [p_LANES*p_INPUT_WIDTH-1:0]  i_WORD,
  input  logic                              i_VALID,
  output logic                              o_READY,
  output logic signed [p_OUTPUT_WIDTH-1:0]  o_SAMPLE,
  output logic                              o_VALID,
  input  logic                              i_READY,
  output logic [LW-1:0]                     o_LANE,
  output logic                              o_LAST,
  output logic                              o_STATE
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // The producer side (o_VALID, o_SAMPLE, o_LANE, o_LAST) holds steady
  // while o_VALID && !i_READY; o_READY never looks at i_VALID or i_READY.

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  localparam int              WW        = p_LANES * p_INPUT_WIDTH;
  localparam logic [LW-1:0]   LAST_LANE = LW'(p_LANES - 1);

  logic [0:0]               state_q;
  logic [LW-1:0]            lane_q;
  logic [WW-1:0]            word_q;

  logic                     in_xfer;
  logic                     out_xfer;
  logic                     lane_is_last;
  logic [p_INPUT_WIDTH-1:0] lane_val;

  assign in_xfer      = i_VALID && o_READY;
  assign out_xfer     = o_VALID && i_READY;
  assign lane_is_last = (lane_q == LAST_LANE);

  // Lane mux over the held word; lanes beyond p_LANES-1 are unreachable.
  always_comb begin
    lane_val = '0;
    for (int i = 0; i < p_LANES; i++) begin
      if (lane_q == LW'(i)) begin
        lane_val = word_q[i*p_INPUT_WIDTH +: p_INPUT_WIDTH];
      end
    end
  end

  generate
    if (p_OUTPUT_WIDTH > p_INPUT_WIDTH) begin : g_extend
      assign o_SAMPLE = {{(p_OUTPUT_WIDTH - p_INPUT_WIDTH){lane_val[p_INPUT_WIDTH-1]}}, lane_val};
    end else begin : g_same
      assign o_SAMPLE = lane_val;
    end
  endgenerate

  assign o_VALID = (state_q == S_DRAIN);
  assign o_LANE  = lane_q;
  assign o_LAST  = o_VALID && lane_is_last;
  assign o_STATE = state_q[0];

`ifdef SIGN_EXTEND_UNPACKER_PREFETCH_EN

  logic [WW-1:0] pf_word_q;
  logic          pf_full_q;

  assign o_READY = !pf_full_q && !i_RST;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q   <= S_IDLE;
      lane_q    <= '0;
      word_q    <= '0;
      pf_word_q <= '0;
      pf_full_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_xfer) begin
            word_q  <= i_WORD;
            lane_q  <= '0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_xfer && lane_is_last) begin
            // End of word: pick the next word from the slot, then the input, else go idle.
            if (pf_full_q) begin
              word_q    <= pf_word_q;
              lane_q    <= '0;
              pf_full_q <= 1'b0;
            end else if (in_xfer) begin
              word_q <= i_WORD;
              lane_q <= '0;
            end else begin
              lane_q  <= '0;
              state_q <= S_IDLE;
            end
          end else begin
            if (out_xfer) begin
              lane_q <= lane_q + LW'(1);
            end
            if (in_xfer) begin
              pf_word_q <= i_WORD;
              pf_full_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          lane_q  <= '0;
        end
      endcase
    end
  end

`else

  assign o_READY = (state_q == S_IDLE) && !i_RST;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      word_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_xfer) begin
            word_q  <= i_WORD;
            lane_q  <= '0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_xfer) begin
            if (lane_is_last) begin
              lane_q  <= '0;
              state_q <= S_IDLE;
            end else begin
              lane_q <= lane_q + LW'(1);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          lane_q  <= '0;
        end
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_sign_extend_unpacker.sv
// Directed vector table, hand-written corner sequences and a random scoreboard run
// for sign_extend_unpacker (4-bit lanes, 8-bit samples, 4 lanes, plus an equal-width instance).
module tb_sign_extend_unpacker;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance
  logic [15:0] i_word;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  o_sample;
  logic        o_valid;
  logic        i_ready;
  logic [1:0]  o_lane;
  logic        o_last;
  logic        o_state;

  // equal-width instance
  logic [15:0] eq_word;
  logic        eq_ivalid;
  logic        eq_oready;
  logic [3:0]  eq_sample;
  logic        eq_ovalid;
  logic        eq_iready;
  logic [1:0]  eq_lane;
  logic        eq_last;
  logic        eq_state;

  sign_extend_unpacker #(.p_INPUT_WIDTH(4), .p_OUTPUT_WIDTH(8), .p_LANES(4)) dut (
    .i_CLK(clk), .i_RST(rst), .i_WORD(i_word), .i_VALID(i_valid), .o_READY(o_ready),
    .o_SAMPLE(o_sample), .o_VALID(o_valid), .i_READY(i_ready), .o_LANE(o_lane),
    .o_LAST(o_last), .o_STATE(o_state)
  );

  sign_extend_unpacker #(.p_INPUT_WIDTH(4), .p_OUTPUT_WIDTH(4), .p_LANES(4)) dut_eq (
    .i_CLK(clk), .i_RST(rst), .i_WORD(eq_word), .i_VALID(eq_ivalid), .o_READY(eq_oready),
    .o_SAMPLE(eq_sample), .o_VALID(eq_ovalid), .i_READY(eq_iready), .o_LANE(eq_lane),
    .o_LAST(eq_last), .o_STATE(eq_state)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sext(input logic [3:0] v);
    return {{4{v[3]}}, v};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_ready) chk("wait_ready_timeout", {31'd0, o_ready}, 32'd1);
  endtask

  task automatic send_word(input logic [15:0] w);
    wait_ready();
    i_word  = w;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic check_out(input string name, input logic [1:0] lane, input logic [7:0] sample);
    chk({name, "_valid"}, {31'd0, o_valid}, 32'd1);
    chk({name, "_lane"}, {30'd0, o_lane}, {30'd0, lane});
    chk({name, "_sample"}, {24'd0, o_sample}, {24'd0, sample});
    chk({name, "_last"}, {31'd0, o_last}, {31'd0, (lane == 2'd3)});
  endtask

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];   // {lane, sample}
  logic       sb_en = 1'b0;
  logic       prev_stall = 1'b0;
  logic [9:0] prev_out;

  always @(negedge clk) begin
    if (sb_en) begin
      if (prev_stall) chk("sb_stable", {21'd0, o_valid, o_lane, o_sample}, {21'd0, 1'b1, prev_out});
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: got lane %0d sample %0h expected nothing", o_lane, o_sample);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          chk("sb_lane", {30'd0, o_lane}, {30'd0, e[9:8]});
          chk("sb_sample", {24'd0, o_sample}, {24'd0, e[7:0]});
          chk("sb_last", {31'd0, o_last}, {31'd0, (e[9:8] == 2'd3)});
        end
      end
      if (i_valid && o_ready) begin
        for (int l = 0; l < 4; l++) begin
          logic [3:0] nib;
          nib = i_word[l*4 +: 4];
          exp_q.push_back({2'(l), sext(nib)});
        end
      end
      prev_stall = o_valid && !i_ready;
      prev_out   = {o_lane, o_sample};
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] word;
    logic [7:0]  exp [4];
  } vec_t;

  vec_t vecs [6];

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_cmp++;
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- main sequence ----------------
  logic drv_done;

  initial begin
    vecs[0].word = 16'h9A7F; vecs[0].exp = '{8'hFF, 8'h07, 8'hFA, 8'hF9};
    vecs[1].word = 16'h8001; vecs[1].exp = '{8'h01, 8'h00, 8'h00, 8'hF8};
    vecs[2].word = 16'h1234; vecs[2].exp = '{8'h04, 8'h03, 8'h02, 8'h01};
    vecs[3].word = 16'h7F80; vecs[3].exp = '{8'h00, 8'hF8, 8'hFF, 8'h07};
    vecs[4].word = 16'h0000; vecs[4].exp = '{8'h00, 8'h00, 8'h00, 8'h00};
    vecs[5].word = 16'h5A5A; vecs[5].exp = '{8'hFA, 8'h05, 8'hFA, 8'h05};

    rst = 1'b1;
    i_word = '0; i_valid = 1'b0; i_ready = 1'b0;
    eq_word = '0; eq_ivalid = 1'b0; eq_iready = 1'b0;
    drv_done = 1'b0;

    // reset state
    #1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd0);
    chk("rst_sample", {24'd0, o_sample}, 32'd0);
    chk("rst_lane", {30'd0, o_lane}, 32'd0);
    chk("rst_last", {31'd0, o_last}, 32'd0);
    chk("rst_state", {31'd0, o_state}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, o_ready}, 32'd1);

    // table-driven vectors, consumer always ready
    i_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      send_word(vecs[v].word);
      for (int l = 0; l < 4; l++) begin
        check_out($sformatf("vec%0d_l%0d", v, l), 2'(l), vecs[v].exp[l]);
        @(posedge clk); #1;
      end
      chk($sformatf("vec%0d_bubble", v), {31'd0, o_valid}, 32'd0);
    end

    // backpressure on lane 1
    send_word(16'h8001);
    check_out("bp_l0", 2'd0, 8'h01);
    @(posedge clk); #1;
    i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_out($sformatf("bp_hold%0d", c), 2'd1, 8'h00);
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    check_out("bp_l1", 2'd1, 8'h00);
    @(posedge clk); #1;
    check_out("bp_l2", 2'd2, 8'h00);
    @(posedge clk); #1;
    check_out("bp_l3", 2'd3, 8'hF8);
    @(posedge clk); #1;
    chk("bp_done", {31'd0, o_valid}, 32'd0);

    // reset in the middle of a word
    send_word(16'hFFFF);
    check_out("mr_l0", 2'd0, 8'hFF);
    @(posedge clk); #1;
    check_out("mr_l1", 2'd1, 8'hFF);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mr_valid", {31'd0, o_valid}, 32'd0);
    chk("mr_sample", {24'd0, o_sample}, 32'd0);
    chk("mr_lane", {30'd0, o_lane}, 32'd0);
    chk("mr_last", {31'd0, o_last}, 32'd0);
    chk("mr_ready", {31'd0, o_ready}, 32'd0);
    @(posedge clk); #1;
    chk("mr_ready_hold", {31'd0, o_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mr_ready_release", {31'd0, o_ready}, 32'd1);
    send_word(16'h1234);
    check_out("mr_next_l0", 2'd0, 8'h04);
    for (int l = 1; l < 4; l++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("mr_next_done", {31'd0, o_valid}, 32'd0);

`ifdef SIGN_EXTEND_UNPACKER_PREFETCH_EN
    // back-to-back words through the prefetch slot
    wait_ready();
    i_word  = 16'h1111;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_word  = 16'hEEEE;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("b2b_ready_full", {31'd0, o_ready}, 32'd0);
    check_out("b2b_w0_l1", 2'd1, 8'h01);
    @(posedge clk); #1;
    check_out("b2b_w0_l2", 2'd2, 8'h01);
    @(posedge clk); #1;
    check_out("b2b_w0_l3", 2'd3, 8'h01);
    @(posedge clk); #1;
    for (int l = 0; l < 4; l++) begin
      check_out($sformatf("b2b_w1_l%0d", l), 2'(l), 8'hFE);
      if (l == 0) chk("b2b_ready_empty", {31'd0, o_ready}, 32'd1);
      @(posedge clk); #1;
    end
    chk("b2b_done", {31'd0, o_valid}, 32'd0);
`endif

    // equal widths: lane passes through unchanged
    eq_iready = 1'b1;
    eq_word   = 16'hC3A5;
    eq_ivalid = 1'b1;
    chk("eq_ready", {31'd0, eq_oready}, 32'd1);
    @(posedge clk); #1;
    eq_ivalid = 1'b0;
    begin
      logic [3:0] eq_exp [4];
      eq_exp = '{4'h5, 4'hA, 4'h3, 4'hC};
      for (int l = 0; l < 4; l++) begin
        chk($sformatf("eq_l%0d_valid", l), {31'd0, eq_ovalid}, 32'd1);
        chk($sformatf("eq_l%0d_sample", l), {28'd0, eq_sample}, {28'd0, eq_exp[l]});
        chk($sformatf("eq_l%0d_lane", l), {30'd0, eq_lane}, l);
        chk($sformatf("eq_l%0d_last", l), {31'd0, eq_last}, {31'd0, (l == 3)});
        @(posedge clk); #1;
      end
    end
    chk("eq_done", {31'd0, eq_ovalid}, 32'd0);

    // random valid/ready traffic against the scoreboard
    exp_q.delete();
    sb_en = 1'b1;
    fork
      begin : producer
        for (int w = 0; w < 1000; w++) begin
          int  n;
          logic acc;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          i_word  = 16'($urandom_range(0, 16'hFFFF));
          i_valid = 1'b1;
          n = 0;
          do begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk); #1;
            n++;
          end while (!acc && n < 100);
          if (!acc) chk("rnd_accept_timeout", {31'd0, acc}, 32'd1);
          i_valid = 1'b0;
        end
        drv_done = 1'b1;
      end
      begin : consumer
        while (!drv_done) begin
          i_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        i_ready = 1'b1;
      end
    join
    begin
      int n = 0;
      while ((exp_q.size() != 0 || o_valid) && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("sb_drain", exp_q.size(), 32'd0);
    sb_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
